// File: rtl/write_back_ext.sv
// Write-back stage: registers one retiring instruction per cycle, selects and
// extends its result, suppresses x0 writes and counts retired instructions.
module write_back_ext #(
    parameter int XLEN    = 64,
    parameter int CNT_W   = 64,
    parameter bit ZERO_X0 = 1'b1,
    localparam int AW     = $clog2(XLEN / 8)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic             i_reg_write,
    input  logic [1:0]       i_wb_sel,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_mem_data,
    input  logic [AW-1:0]    i_mem_addr_lo,
    input  logic [XLEN-1:0]  i_pc_plus4,
    input  logic [XLEN-1:0]  i_imm,
    output logic [4:0]       o_rd_index,
    output logic [XLEN-1:0]  o_rd_data,
    output logic             o_rd_we,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_instret
);

    logic [4:0]       w_rd;
    logic [2:0]       w_f3;
    logic             w_accept;
    logic             w_x0;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_lw;
    logic [XLEN-1:0]  w_lwu;
    logic [XLEN-1:0]  w_load;
    logic [XLEN-1:0]  w_result;
    logic             w_unused;

    logic             r_valid;
    logic             r_rd_we;
    logic [4:0]       r_rd_index;
    logic [XLEN-1:0]  r_rd_data;
    logic [CNT_W-1:0] r_instret;

    assign w_rd     = i_instruction[11:7];
    assign w_f3     = i_instruction[14:12];
    assign w_unused = ^{i_instruction[31:15], i_instruction[6:0]};
    assign w_accept = i_valid & ~i_stall & ~i_flush;
    assign w_x0     = ZERO_X0 && (w_rd == 5'd0);
    assign o_ready  = ~i_stall;

    // Offsets are aligned down to the access size by dropping low address bits
    assign w_byte = i_mem_data[{i_mem_addr_lo, 3'b000} +: 8];
    assign w_half = i_mem_data[{i_mem_addr_lo[AW-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_x64
            logic [31:0] w_word;
            assign w_word = i_mem_data[{i_mem_addr_lo[AW-1], 5'b00000} +: 32];
            assign w_lw   = {{(XLEN-32){w_word[31]}}, w_word};
            assign w_lwu  = {{(XLEN-32){1'b0}}, w_word};
        end else begin : g_x32
            assign w_lw  = i_mem_data;
            assign w_lwu = i_mem_data;
        end
    endgenerate

    always_comb begin
        w_load = i_mem_data;
        case (w_f3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            3'b010:  w_load = w_lw;
            3'b110:  w_load = w_lwu;
            default: w_load = i_mem_data;
        endcase
    end

    always_comb begin
        w_result = i_alu_result;
        case (i_wb_sel)
            2'b00:   w_result = i_alu_result;
            2'b01:   w_result = w_load;
            2'b10:   w_result = i_pc_plus4;
            default: w_result = i_imm;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_rd_we    <= 1'b0;
            r_rd_index <= 5'd0;
            r_rd_data  <= '0;
            r_instret  <= '0;
        end else begin
            r_valid <= w_accept;
            r_rd_we <= w_accept & i_reg_write & ~w_x0;
            if (w_accept) begin
                r_rd_index <= w_rd;
                r_rd_data  <= w_result;
            end
            // Counts the instruction currently shown on the outputs
            if (r_valid) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign o_valid    = r_valid;
    assign o_rd_we    = r_rd_we;
    assign o_rd_index = r_rd_index;
    assign o_rd_data  = r_rd_data;
    assign o_instret  = r_instret;

endmodule

// File: tb/tb_write_back_ext.sv
// Directed bench for write_back_ext: a 64-bit default instance plus a
// CNT_W=4, ZERO_X0=0 instance sharing the same stimulus.
module tb_write_back_ext;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [2:0]  addr_lo;
    logic [63:0] pc4;
    logic [63:0] imm;

    logic        a_ready, a_we, a_valid;
    logic [4:0]  a_idx;
    logic [63:0] a_data;
    logic [63:0] a_cnt;

    logic        b_ready, b_we, b_valid;
    logic [4:0]  b_idx;
    logic [63:0] b_data;
    logic [3:0]  b_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_cnt   = '0;

    write_back_ext u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
        .i_flush(flush), .o_ready(a_ready), .i_instruction(instr),
        .i_reg_write(reg_write), .i_wb_sel(wb_sel), .i_alu_result(alu),
        .i_mem_data(mem), .i_mem_addr_lo(addr_lo), .i_pc_plus4(pc4),
        .i_imm(imm), .o_rd_index(a_idx), .o_rd_data(a_data),
        .o_rd_we(a_we), .o_valid(a_valid), .o_instret(a_cnt)
    );

    write_back_ext #(.XLEN(64), .CNT_W(4), .ZERO_X0(1'b0)) u_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
        .i_flush(flush), .o_ready(b_ready), .i_instruction(instr),
        .i_reg_write(reg_write), .i_wb_sel(wb_sel), .i_alu_result(alu),
        .i_mem_data(mem), .i_mem_addr_lo(addr_lo), .i_pc_plus4(pc4),
        .i_imm(imm), .o_rd_index(b_idx), .o_rd_data(b_data),
        .o_rd_we(b_we), .o_valid(b_valid), .o_instret(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, 7'b0000011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; acc says whether the bench expects this edge to accept
    task automatic cyc(input logic acc);
        @(posedge clk);
        #1;
        if (m_valid) m_cnt = m_cnt + 64'd1;
        m_valid = acc;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic we,
                           input logic [4:0] idx, input logic [63:0] d);
        chk({tag, ".valid"}, {63'd0, a_valid}, {63'd0, v});
        chk({tag, ".we"}, {63'd0, a_we}, {63'd0, we});
        chk({tag, ".idx"}, {59'd0, a_idx}, {59'd0, idx});
        chk({tag, ".data"}, a_data, d);
        chk({tag, ".cnt"}, a_cnt, m_cnt);
    endtask

    task automatic mem_ld(input string tag, input logic [2:0] f3,
                          input logic [2:0] off, input logic [63:0] exp);
        instr   = mk(5'd10, f3);
        wb_sel  = 2'b01;
        addr_lo = off;
        cyc(1'b1);
        chk_out(tag, 1'b1, 1'b1, 5'd10, exp);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b1; stall = 1'b0; flush = 1'b0;
        instr = mk(5'd5, 3'b000); reg_write = 1'b1; wb_sel = 2'b00;
        alu = 64'h1234; mem = 64'h8877665544332211; addr_lo = 3'd0;
        pc4 = 64'h0000_0000_8000_0004; imm = 64'hFFFF_FFFF_ABCD_E000;

        @(posedge clk); @(posedge clk); #1;
        chk_out("reset", 1'b0, 1'b0, 5'd0, 64'd0);
        chk("reset.ready", {63'd0, a_ready}, 64'd1);
        rst_n = 1'b1;

        cyc(1'b1);
        chk_out("alu", 1'b1, 1'b1, 5'd5, 64'h1234);

        instr = mk(5'd1, 3'b000); wb_sel = 2'b10;
        cyc(1'b1);
        chk_out("pc4", 1'b1, 1'b1, 5'd1, 64'h0000_0000_8000_0004);

        instr = mk(5'd31, 3'b000); wb_sel = 2'b11;
        cyc(1'b1);
        chk_out("imm", 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_ABCD_E000);

        mem_ld("lb7",  3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF88);
        mem_ld("lbu7", 3'b100, 3'd7, 64'h0000_0000_0000_0088);
        mem_ld("lhu3", 3'b101, 3'd3, 64'h0000_0000_0000_4433);
        mem_ld("lh6",  3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8877);
        mem_ld("lw4",  3'b010, 3'd4, 64'hFFFF_FFFF_8877_6655);
        mem_ld("lwu5", 3'b110, 3'd5, 64'h0000_0000_8877_6655);
        mem_ld("ld",   3'b011, 3'd3, 64'h8877_6655_4433_2211);
        mem_ld("f7",   3'b111, 3'd1, 64'h8877_6655_4433_2211);

        instr = mk(5'd0, 3'b000); wb_sel = 2'b00; alu = 64'h55;
        cyc(1'b1);
        chk_out("x0", 1'b1, 1'b0, 5'd0, 64'h55);
        chk("x0.pass_we", {63'd0, b_we}, 64'd1);

        instr = mk(5'd7, 3'b000); alu = 64'hCAFE;
        cyc(1'b1);
        chk_out("pre_stall", 1'b1, 1'b1, 5'd7, 64'hCAFE);

        stall = 1'b1; alu = 64'hDEAD; instr = mk(5'd9, 3'b000);
        #1;
        chk("stall.ready", {63'd0, a_ready}, 64'd0);
        cyc(1'b0);
        chk_out("stall1", 1'b0, 1'b0, 5'd7, 64'hCAFE);
        cyc(1'b0);
        chk_out("stall2", 1'b0, 1'b0, 5'd7, 64'hCAFE);
        stall = 1'b0; flush = 1'b1;
        cyc(1'b0);
        chk_out("flush", 1'b0, 1'b0, 5'd7, 64'hCAFE);
        stall = 1'b1;
        cyc(1'b0);
        chk_out("stall_flush", 1'b0, 1'b0, 5'd7, 64'hCAFE);
        stall = 1'b0; flush = 1'b0; valid = 1'b0;
        cyc(1'b0);
        chk_out("novalid", 1'b0, 1'b0, 5'd7, 64'hCAFE);

        valid = 1'b1;
        cyc(1'b1);
        chk_out("resume", 1'b1, 1'b1, 5'd9, 64'hDEAD);

        #3 rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_cnt = '0;
        chk_out("async_rst", 1'b0, 1'b0, 5'd0, 64'd0);
        chk("async_rst.cnt4", {60'd0, b_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) cyc(1'b1);
        chk("wrap16.cnt64", a_cnt, 64'd16);
        chk("wrap16.cnt4", {60'd0, b_cnt}, 64'd0);
        valid = 1'b0;
        cyc(1'b0);
        chk("wrap17.cnt64", a_cnt, 64'd17);
        chk("wrap17.cnt4", {60'd0, b_cnt}, 64'd1);
        chk("wrap17.valid", {63'd0, b_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
